// File: rtl/mdu_ctrl.sv
// mdu_ctrl: issue/stall control for a multi-cycle multiply/divide unit.
// Strobes are combinational in the issue cycle; busy tracks the unit's latency.
module mdu_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        e_valid,
    input  logic [2:0]  e_op,
    input  logic        d_is_md,
    output logic        mdu_start,
    output logic [2:0]  mdu_op,
    output logic        hi_we,
    output logic        lo_we,
    output logic        busy,
    output logic        stall_d,
    output logic [15:0] op_cnt,
    output logic [15:0] stall_cnt
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] op_cnt_q, stall_cnt_q;
    logic        issue;
    // Reset gates issue so no strobe escapes while the unit is being cleared.
    assign issue     = state_q == IDLE && e_valid && !Req && !reset;
    assign mdu_start = issue && e_op >= 3'd1 && e_op <= 3'd4;
    assign hi_we     = issue && e_op == 3'd5;
    assign lo_we     = issue && e_op == 3'd6;
    assign mdu_op    = (mdu_start || hi_we || lo_we) ? e_op : 3'd0;
    assign busy      = state_q == RUN;
    assign stall_d   = d_is_md && (busy || mdu_start);
    assign op_cnt    = op_cnt_q;
    assign stall_cnt = stall_cnt_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            op_cnt_q    <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            if (mdu_start) begin
                state_q <= RUN;
                cnt_q   <= e_op <= 3'd2 ? 4'(MULT_LAT) : 4'(DIV_LAT);
            end else if (state_q == RUN && !Req) begin
                cnt_q <= cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_q <= IDLE;
            end
            if (mdu_start || hi_we || lo_we) op_cnt_q <= op_cnt_q + 16'd1;
            if (stall_d && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end
endmodule
